// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, initial hash values, FSM state encoding,
// and the FIPS 180-4 logical functions used by the compression datapath.
package sha256_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned NUM_WORDS = 8;
   localparam int unsigned WIN_WORDS = 16;
   localparam int unsigned CTR_W     = 6;
   localparam int unsigned BLOCK_W   = WORD_W * WIN_WORDS;
   localparam int unsigned DIGEST_W  = WORD_W * NUM_WORDS;
   localparam int unsigned ROUNDS    = 64;

   typedef logic [WORD_W-1:0] word_t;

   // Index 0 is the most significant word (H0 / a / W0).
   typedef logic [0:NUM_WORDS-1][WORD_W-1:0] hash_t;
   typedef logic [0:WIN_WORDS-1][WORD_W-1:0] window_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUNDS,
      ST_FINAL
   } state_t;

   localparam hash_t H_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic word_t big_sigma0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/k_constants.sv
// SHA-256 round constant ROM.
// Ports: addr - round index 0..63; k_c - combinational round constant K[addr].
module k_constants
   import sha256_pkg::*;
(
   input  logic [CTR_W-1:0]  addr,
   output logic [WORD_W-1:0] k_c
);

   localparam logic [WORD_W-1:0] K_TABLE [ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   assign k_c = K_TABLE[addr];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 single-block compression engine, one round per clock.
// Ports:
//   clk, reset_n      - clock and synchronous active-low reset
//   init              - accept block, chaining on the SHA-256 IV
//   next              - accept block, chaining on the current digest
//   block             - 512-bit message block, W0 in block[511:480]
//   ready             - idle and able to accept init/next
//   digest            - H0 in digest[255:224] .. H7 in digest[31:0]
//   digest_valid      - digest holds a completed result
module sha256_compress
   import sha256_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                init,
   input  logic                next,
   input  logic [BLOCK_W-1:0]  block,
   output logic                ready,
   output logic [DIGEST_W-1:0] digest,
   output logic                digest_valid
);

   state_t             state_q;
   state_t             state_d;
   logic [CTR_W-1:0]   w_ctr_q;
   window_t            window_q;
   hash_t              work_q;
   logic               use_iv_q;

   logic               accept_c;
   logic               load_c;
   logic               round_c;
   logic               final_c;
   word_t              k_c;
   word_t              w_new_c;
   word_t              t1_c;
   word_t              t2_c;
   hash_t              work_next_c;
   hash_t              hash_base_c;
   hash_t              digest_next_c;

   k_constants u_k_constants (
      .addr (w_ctr_q),
      .k_c  (k_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      accept_c = ready & (init | next);
      load_c   = 1'b0;
      round_c  = 1'b0;
      final_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               load_c  = 1'b1;
               state_d = ST_ROUNDS;
            end
         end
         ST_ROUNDS: begin
            round_c = 1'b1;
            if (w_ctr_q == CTR_W'(ROUNDS - 1)) begin
               state_d = ST_FINAL;
            end
         end
         ST_FINAL: begin
            final_c = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Round function; window_q[0] is always the current W_t, and the new
   // word W_t+16 is appended as the window slides.
   always_comb begin
      w_new_c = small_sigma1(window_q[14]) + window_q[9]
              + small_sigma0(window_q[1]) + window_q[0];
      t1_c    = work_q[7] + big_sigma1(work_q[4])
              + ch(work_q[4], work_q[5], work_q[6]) + k_c + window_q[0];
      t2_c    = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
      work_next_c = {t1_c + t2_c, work_q[0], work_q[1], work_q[2],
                     work_q[3] + t1_c, work_q[4], work_q[5], work_q[6]};
      // digest is untouched during ROUNDS, so it still holds the chain base
      hash_base_c = use_iv_q ? H_IV : hash_t'(digest);
      for (int i = 0; i < NUM_WORDS; i++) begin
         digest_next_c[i] = hash_base_c[i] + work_q[i];
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ready        <= 1'b1;
         digest_valid <= 1'b0;
         digest       <= '0;
         w_ctr_q      <= '0;
         window_q     <= '0;
         work_q       <= '0;
         use_iv_q     <= 1'b0;
      end else begin
         if (load_c) begin
            window_q     <= window_t'(block);
            work_q       <= init ? H_IV : hash_t'(digest);
            use_iv_q     <= init;
            w_ctr_q      <= '0;
            ready        <= 1'b0;
            digest_valid <= 1'b0;
         end
         if (round_c) begin
            work_q   <= work_next_c;
            window_q <= {window_q[1:WIN_WORDS-1], w_new_c};
            w_ctr_q  <= w_ctr_q + CTR_W'(1);
         end
         if (final_c) begin
            digest       <= DIGEST_W'(digest_next_c);
            digest_valid <= 1'b1;
            ready        <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known-answer vectors, control
// corner cases, and random blocks against a full-schedule reference model.
module tb_sha256_compress;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         init;
   logic         next;
   logic [511:0] block;
   logic         ready;
   logic [255:0] digest;
   logic         digest_valid;

   int checks   = 0;
   int failures = 0;

   localparam logic [255:0] IV_REF =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K_REF [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_M1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};

   localparam logic [255:0] DIG_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DIG_TWO =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   sha256_compress dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .init         (init),
      .next         (next),
      .block        (block),
      .ready        (ready),
      .digest       (digest),
      .digest_valid (digest_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_compress(input logic [255:0] h_in, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  t1, t2, s0, s1;
      logic [255:0] res;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int i = 0; i < 8; i++) v[i] = h_in[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_REF[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = h_in[255 - 32*i -: 32] + v[i];
      return res;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one accept, then wait (bounded) for digest_valid. Optionally pulse
   // init/next with junk blocks while rounds are in flight.
   task automatic run_op(input string tag, input bit do_init, input bit do_next,
                         input logic [511:0] blk, input bit disturb,
                         output int lat, output bit held);
      logic [255:0] prev;
      block = blk;
      init  = do_init;
      next  = do_next;
      step();
      init  = 1'b0;
      next  = 1'b0;
      block = '0;
      check({tag, "_ready_drop"}, 256'(ready), 256'(0));
      check({tag, "_valid_drop"}, 256'(digest_valid), 256'(0));
      prev = digest;
      held = 1'b1;
      lat  = 0;
      while (!digest_valid && lat < 200) begin
         if (disturb && lat >= 10 && lat < 20) begin
            init  = lat[0];
            next  = !lat[0];
            block = rand_block();
         end else begin
            init  = 1'b0;
            next  = 1'b0;
         end
         step();
         lat++;
         if (!digest_valid && digest !== prev) held = 1'b0;
      end
      init  = 1'b0;
      next  = 1'b0;
      block = '0;
      check({tag, "_latency"}, 256'(lat), 256'(65));
      check({tag, "_ready_up"}, 256'(ready), 256'(1));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int           lat;
      bit           held;
      logic [511:0] blk;
      logic [255:0] exp;
      logic [255:0] model_h;
      int           sel;

      reset_n = 1'b0;
      init    = 1'b0;
      next    = 1'b0;
      block   = '0;
      step();
      step();
      check("reset_ready", 256'(ready), 256'(1));
      check("reset_valid", 256'(digest_valid), 256'(0));
      check("reset_digest", digest, 256'(0));
      reset_n = 1'b1;
      step();

      // next with no prior init chains on the all-zero digest
      blk = rand_block();
      run_op("next_from_zero", 1'b0, 1'b1, blk, 1'b0, lat, held);
      check("next_from_zero_digest", digest, ref_compress(256'(0), blk));

      run_op("abc", 1'b1, 1'b0, BLK_ABC, 1'b0, lat, held);
      check("abc_digest", digest, DIG_ABC);
      check("abc_valid", 256'(digest_valid), 256'(1));
      check("abc_digest_held", 256'(held), 256'(1));

      run_op("empty", 1'b1, 1'b0, BLK_EMPTY, 1'b0, lat, held);
      check("empty_digest", digest, DIG_EMPTY);

      // two-block message, second accept on the cycle ready rises
      run_op("two_b1", 1'b1, 1'b0, BLK_M1, 1'b0, lat, held);
      check("two_b1_digest", digest, ref_compress(IV_REF, BLK_M1));
      run_op("two_b2", 1'b0, 1'b1, BLK_M2, 1'b0, lat, held);
      check("two_b2_digest", digest, DIG_TWO);
      check("two_b2_held", 256'(held), 256'(1));

      // init wins over next
      run_op("both", 1'b1, 1'b1, BLK_ABC, 1'b0, lat, held);
      check("both_digest", digest, DIG_ABC);

      // init/next during rounds are ignored
      run_op("disturb", 1'b1, 1'b0, BLK_ABC, 1'b1, lat, held);
      check("disturb_digest", digest, DIG_ABC);
      check("disturb_held", 256'(held), 256'(1));

      // reset at round 30 aborts the run
      block = BLK_ABC;
      init  = 1'b1;
      step();
      init  = 1'b0;
      block = '0;
      repeat (30) step();
      check("midrun_busy", 256'(ready), 256'(0));
      reset_n = 1'b0;
      step();
      check("midrun_reset_ready", 256'(ready), 256'(1));
      check("midrun_reset_valid", 256'(digest_valid), 256'(0));
      check("midrun_reset_digest", digest, 256'(0));
      reset_n = 1'b1;
      run_op("after_reset", 1'b1, 1'b0, BLK_ABC, 1'b0, lat, held);
      check("after_reset_digest", digest, DIG_ABC);

      // random chains against the reference model
      model_h = DIG_ABC;
      for (int n = 0; n < 8; n++) begin
         blk = rand_block();
         sel = int'($urandom_range(0, 2));
         exp = (sel != 1) ? ref_compress(IV_REF, blk) : ref_compress(model_h, blk);
         run_op("rand", sel != 1, sel != 0, blk, n[0], lat, held);
         check("rand_digest", digest, exp);
         model_h = exp;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
